// File: rtl/alu_cmd_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_driver_if
//  Description : Command, ALU-side and result signals of the ALU command
//                driver. The slave modport is the driver's view; the master
//                modport is the surrounding host/ALU environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_cmd_driver_if;
  // Command port
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  // ALU drive and observe
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_rst;
  logic [31:0] alu_f;
  logic        alu_zf;
  logic        alu_cf;
  logic        alu_of;
  logic        alu_sf;
  logic        alu_pf;
  // Result port
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_f;
  logic [4:0]  res_flags;
  logic        res_err;
  logic [7:0]  res_cycles;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_f, alu_zf, alu_cf, alu_of, alu_sf, alu_pf,
    input  res_ready,
    output cmd_ready,
    output alu_op, alu_a, alu_b, alu_rst,
    output res_valid, res_f, res_flags, res_err, res_cycles
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_f, alu_zf, alu_cf, alu_of, alu_sf, alu_pf,
    output res_ready,
    input  cmd_ready,
    input  alu_op, alu_a, alu_b, alu_rst,
    input  res_valid, res_f, res_flags, res_err, res_cycles
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_driver
//  Description : One-at-a-time command sequencer for the 32-bit ALU. Drives
//                OP/A/B, pulses the multiplier start, waits the fixed
//                latency and holds F plus flags behind a valid/ready port.
//                Optional macro ALU_DRV_LATENCY_EN adds an acceptance-to-
//                capture cycle counter on res_cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_driver #(
  parameter int SETTLE_CYCLES = 1,   // 1..15
  parameter int MUL_CYCLES    = 34   // 1..255
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_MUL_START = 3'd2,
    S_MUL_WAIT  = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  localparam logic [3:0] c_op_mul      = 4'b1000;
  localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_mul_last    = 8'(MUL_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_err_pend;
  logic        w_accept;
  logic        w_capture;
  logic        w_legal;

  assign w_legal = (bus.cmd_op <= c_op_mul);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, handshake decode and capture strobe.
  // Illegal opcodes pass through SETTLE for exactly one cycle so their
  // result appears one edge after acceptance, like a default-latency op.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.cmd_op == c_op_mul) ? S_MUL_START : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_err_pend || (r_cnt == c_settle_last)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_MUL_START: w_state_nxt = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (r_cnt == c_mul_last) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU drive registers, wait counter and result capture.
  // The counter is zeroed at acceptance; MUL_START leaves it at zero so the
  // multiply wait starts counting on the edge that ends the start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_op    <= 4'd0;
      bus.alu_a     <= 32'd0;
      bus.alu_b     <= 32'd0;
      bus.alu_rst   <= 1'b0;
      bus.res_f     <= 32'd0;
      bus.res_flags <= 5'd0;
      bus.res_err   <= 1'b0;
      r_cnt         <= 8'd0;
      r_err_pend    <= 1'b0;
    end else begin
      bus.alu_rst <= (r_state == S_MUL_START);
      if (w_accept) begin
        r_cnt      <= 8'd0;
        r_err_pend <= !w_legal;
        if (w_legal) begin
          bus.alu_op <= bus.cmd_op;
          bus.alu_a  <= bus.cmd_a;
          bus.alu_b  <= bus.cmd_b;
        end
      end else if (((r_state == S_SETTLE) || (r_state == S_MUL_WAIT)) && !w_capture) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        bus.res_f     <= r_err_pend ? 32'd0 : bus.alu_f;
        bus.res_flags <= r_err_pend ? 5'd0
                         : {bus.alu_zf, bus.alu_cf, bus.alu_of, bus.alu_sf, bus.alu_pf};
        bus.res_err   <= r_err_pend;
      end
    end
  end

`ifdef ALU_DRV_LATENCY_EN
  logic [7:0] r_lat;

  // Saturating acceptance-to-capture counter; starts at 1 so the value
  // sampled at capture equals the number of edges since acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat          <= 8'd0;
      bus.res_cycles <= 8'd0;
    end else begin
      if (w_accept) begin
        r_lat <= 8'd1;
      end else if ((r_state != S_IDLE) && (r_state != S_HOLD) && (r_lat != 8'hFF)) begin
        r_lat <= r_lat + 8'd1;
      end
      if (w_capture) bus.res_cycles <= r_lat;
    end
  end
`else
  assign bus.res_cycles = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side sequencer for the 32-bit ALU: accepts one operation at a time over a valid/ready command port and drives the ALU's OP/A/B inputs. For multiply it generates the multiplier start pulse. It waits the operation's fixed latency, then captures F and the five flags into a held result register with a valid/ready handshake. It sits between a CPU/host command source and the ALU, replacing free-running stimulus with a cycle-exact, back-pressured interface.

## Interface
- SETTLE_CYCLES, 1: cycles between driving a non-multiply operation and sampling the result (1..15).
- MUL_CYCLES, 34: cycles between the end of the multiply start pulse and sampling the product (1..255).
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver idle and able to accept.
- cmd_op  in  4  ALU opcode.
- cmd_a, cmd_b  in  32  operands.
- alu_op  out  4  to ALU OP.
- alu_a, alu_b  out  32  to ALU A/B.
- alu_rst  out  1  multiplier start pulse, active-high, to ALU Rst.
- alu_f  in  32  ALU result F.
- alu_zf, alu_cf, alu_of, alu_sf, alu_pf  in  1 each  ALU flags.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes result.
- res_f  out  32  captured F.
- res_flags  out  5  captured flags, {ZF,CF,OF,SF,PF} in bits 4..0.
- res_err  out  1  command opcode was illegal.
- res_cycles  out  8  acceptance-to-capture latency; see Configuration.

## Operation
- Legal opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR.
  - 0100 ripple add, 0101 carry-lookahead add.
  - 0110 set-less-than, 0111 shift-left-logical.
  - 1000 multiply.
  - 1001..1111 are illegal.
- States: IDLE, SETTLE, MUL_START, MUL_WAIT, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, register cmd_op/a/b onto alu_op/a/b.
  - Legal non-multiply opcode -> SETTLE.
  - 1000 -> MUL_START.
  - Illegal opcode -> HOLD directly, with res_f=0, res_flags=0, res_err=1. alu_* outputs are not updated.
- SETTLE: count SETTLE_CYCLES, then capture alu_f and the flags, set res_err=0, go to HOLD.
- MUL_START: alu_rst=1 for exactly one cycle, then MUL_WAIT.
- MUL_WAIT: count MUL_CYCLES, then capture and go to HOLD.
- HOLD:
  - res_valid=1; res_* are stable.
  - On res_ready, go to IDLE.
- alu_op/a/b hold their last value in all states, including IDLE after completion.
- cmd_ready=0 in every state except IDLE. Commands never overlap.

## Timing
- Reset values:
  - State IDLE, cmd_ready=1.
  - alu_op=0000, alu_a=0, alu_b=0, alu_rst=0.
  - res_valid=0, res_f=0, res_flags=0, res_err=0, res_cycles=0.
- Let edge k be the acceptance edge.
- Non-multiply: capture at edge k+SETTLE_CYCLES; res_valid is high from that edge.
- Multiply:
  - alu_rst is high between edges k+1 and k+2.
  - Capture is at edge k+1+MUL_CYCLES+1.
- Illegal opcode: res_valid is high from edge k+1.
- Result handshake at edge h (res_valid&&res_ready): res_valid drops and cmd_ready rises after h. The earliest next acceptance is edge h+1.
- res_ready high before res_valid has no effect.
- cmd_valid is ignored while cmd_ready=0.
- Rst low in any state, including mid-multiply:
  - All outputs take their reset values immediately.
  - alu_rst drops without completing its pulse.
  - Counters clear.
  - Any in-flight command is discarded.

## Configuration
- ALU_DRV_LATENCY_EN defined:
  - An 8-bit counter clears on acceptance and increments every cycle until capture.
  - res_cycles = counter value at capture, held with res_*.
  - The counter saturates at 255.
  - Expected values: SETTLE_CYCLES for non-multiply, MUL_CYCLES+2 for multiply, 1 for illegal.
- ALU_DRV_LATENCY_EN undefined: the counter is absent; res_cycles is constant 0.

## Test plan
- AND: op 0000, A=1, B=1, res_ready=1 -> res_valid at edge k+1 (default), res_f=0x00000001, ZF=0, res_err=0.
- CLA add: op 0101, A=B=0xFFFFFFFF -> res_f=0xFFFFFFFE, CF=1, SF=1; with ALU_DRV_LATENCY_EN, res_cycles=1.
- Multiply: op 1000, A=3, B=5 -> exactly one alu_rst high cycle, res_f=0x0000000F at edge k+36; with macro, res_cycles=36.
- Illegal opcode: op 1111 -> res_valid at k+1, res_err=1, res_f=0, alu_op still shows the prior opcode.
- Backpressure: after op 0110 with A=0x7FFFFFFF, B=0x8FFFFFFF, hold res_ready=0 for 10 cycles -> res_f/flags stable, cmd_ready=0, further cmd_valid ignored; res_ready=1 -> cmd_ready=1 the next cycle.
- Reset mid-multiply: Rst low for 2 cycles at MUL_WAIT count 10 -> all outputs at reset values; a following op 0000 with A=B=1 completes normally with res_f=1.
